voice_scheduler: RTL and testbench
==================================

// Module: voice_scheduler
// PURPOSE
//  Sequencer and voice allocator for the shared per-voice pipeline (ADSR RAM, oscillators).
//  Once per sample frame, sweeps every voice through the 4-phase pipeline and sums the enveloped voice samples into one mix sample.
//  Maps incoming MIDI note on/off events to voice slots and issues one keystate update at a time, paced to the ADSR single-entry update buffer.
// PARAMETERS
//  NUM_VOICES  8     voices swept per frame; 1..256
//  SAMPLE_DIV  1024  clocks per sample frame; must be >= 4*NUM_VOICES+4
//  ACC_W       24    mix accumulator width (signed); must be >= 16+clog2(NUM_VOICES)
// PORTS
//  i_clk             in   1   system clock
//  i_reset_n         in   1   asynchronous active-low reset
//  i_note_valid      in   1   MIDI note event present
//  i_note_on         in   1   1 = note-on, 0 = note-off
//  i_note_num        in   7   MIDI note number
//  o_note_ready      out  1   event accepted when valid & ready
//  o_spi_flag        out  1   one-cycle keystate update strobe to ADSR/oscillators
//  o_spi_note_status out  1   keystate for that update
//  o_spi_voice_index out  8   voice slot for that update
//  o_voice_note      out  7   note number held by allocated voice (valid with o_spi_flag)
//  o_voice_index     out  8   voice currently in pipeline
//  o_pipeline_state  out  2   0 read, 1 compute/write, 2 update slot, 3 idle/capture
//  i_voice_sample    in   16  signed enveloped sample for o_voice_index
//  o_mix_sample      out  16  signed saturated frame mix
//  o_mix_valid       out  1   one-cycle strobe, new o_mix_sample
// BEHAVIOUR
//  Reset: all outputs 0 except o_pipeline_state=3 and o_note_ready=1; all voice slots free; steal pointer 0; frame counter 0.
//  Frame counter counts 0..SAMPLE_DIV-1 and wraps. Count 0 starts a sweep.
//  Sweep: voice v = 0..NUM_VOICES-1, 4 cycles each, o_pipeline_state 0,1,2,3, o_voice_index=v.
//  Outside the sweep: o_pipeline_state=3, o_voice_index holds the last voice.
//  Capture: on each cycle with o_pipeline_state==3 in the sweep, acc += sign-extended i_voice_sample. acc cleared at sweep start.
//  Mix output: cycle after voice NUM_VOICES-1 phase 3, o_mix_sample = acc saturated to [-32768,32767]; o_mix_valid pulses for 1 cycle.
//  Slot table per voice: busy bit, note[6:0]. Allocator FSM:
//    IDLE   : o_note_ready=1; on valid&ready latch event -> SEARCH (ready drops the same edge).
//    SEARCH : scan one slot per cycle, index 0..NUM_VOICES-1; record first busy slot with matching note, and lowest free slot.
//    DECIDE : note-on with match -> retrigger that slot. Note-on, no match, free slot -> lowest free. Note-on, no free slot -> steal slot at steal pointer, pointer+1 mod NUM_VOICES.
//             Note-off with match -> that slot, busy:=0. Note-off, no match -> drop, back to IDLE, no strobe.
//             Table update in DECIDE for note-on: busy:=1, note:=i_note_num.
//    ISSUE  : wait until no update is outstanding, then o_spi_flag=1 for 1 cycle with status/index/note; -> IDLE.
//  Outstanding rule: set when o_spi_flag pulses. Cleared on the first o_pipeline_state==2 cycle in a sweep that begins after the pulse.
//    Consequence: at most one keystate update is in flight per drain slot, so the ADSR buffer is never overrun.
//  Retrigger issues note_status=1 even if already on (ADSR sees no edge; intended).
//  Simultaneous: an event accepted during a sweep does not disturb the sweep; sweep and allocator are independent FSMs.
//  Async reset mid-sweep aborts the sweep, drops any latched event and accumulator; no o_mix_valid for that frame.
// STRUCTURE
//  Shared package synth_pkg: pipeline phase constants (PH_READ=0, PH_COMPUTE=1, PH_UPDATE=2, PH_IDLE=3), allocator state encodings, MIDI note width 7.
//  One sub-module: voice_allocator (slot table + SEARCH/DECIDE/ISSUE FSM). Sweep counters and mixer stay in the top level.
// TESTING
//  1 Reset release, NUM_VOICES=8, SAMPLE_DIV=64: sweep at count 0 gives states 0,1,2,3 x8 voices (32 cycles); idle state=3; o_mix_valid period 64.
//  2 i_voice_sample=+1000 for all voices -> o_mix_sample=8000. Then +32767 for all -> 32767 (saturated). Then -32768 for all -> -32768.
//  3 Note-on 60, 62, 64 -> flags on voices 0,1,2, status 1. Note-off 62 -> voice 1, status 0. Note-on 65 -> voice 1 (lowest free).
//  4 Nine note-ons 60..68 with 8 voices -> the ninth steals voice 0 (steal ptr 0->1); a further new note steals voice 1.
//  5 Note-off 99 never on -> no o_spi_flag, o_note_ready returns high. Note-on 60 twice -> both flags on the same voice.
//  6 Two events back-to-back before any sweep -> second flag withheld until after a sweep's PH_UPDATE cycle; assert never two flags without an intervening PH_UPDATE.
//    Assert reset_n low mid-sweep -> state=3, flags 0, no mix strobe until the next full frame.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared constants for the voice pipeline: phase codes, allocator states, MIDI widths.
package synth_pkg;

    localparam int unsigned NOTE_W = 7;

    // Per-voice pipeline phases as seen on o_pipeline_state
    localparam logic [1:0] PH_READ    = 2'd0;
    localparam logic [1:0] PH_COMPUTE = 2'd1;
    localparam logic [1:0] PH_UPDATE  = 2'd2;
    localparam logic [1:0] PH_IDLE    = 2'd3;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSearch = 2'd1,
        StDecide = 2'd2,
        StIssue  = 2'd3
    } alloc_state_e;

endpackage

// File: rtl/voice_allocator.sv
// Voice slot table and note-event allocator. Issues at most one keystate update per
// ADSR drain slot: a new update waits until a sweep that started after the previous
// update has passed its first PH_UPDATE cycle.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              note_valid_i,
    input  logic              note_on_i,
    input  logic [NOTE_W-1:0] note_num_i,
    output logic              note_ready_o,
    input  logic              sweep_start_i,
    input  logic              slot_update_i,
    output logic              spi_flag_o,
    output logic              spi_note_status_o,
    output logic [7:0]        spi_voice_index_o,
    output logic [NOTE_W-1:0] voice_note_o
);

    localparam int unsigned     IdxW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_VOICES - 1);

    alloc_state_e      state_q;
    logic              busy_q [NUM_VOICES];
    logic [NOTE_W-1:0] note_q [NUM_VOICES];
    logic              ev_on_q;
    logic [NOTE_W-1:0] ev_note_q;
    logic [IdxW-1:0]   scan_q, match_idx_q, free_idx_q, steal_q;
    logic              match_q, free_q;
    logic              ready_q, flag_q, status_q;
    logic [7:0]        index_q;
    logic [NOTE_W-1:0] vnote_q;
    logic              outstanding_q, armed_q;

    logic [IdxW-1:0]   tgt;
    logic              use_steal, drop;

    // Slot choice for the latched event once the scan has completed
    always_comb begin
        tgt       = steal_q;
        use_steal = 1'b0;
        drop      = 1'b0;
        if (match_q) begin
            tgt = match_idx_q;
        end else if (ev_on_q && free_q) begin
            tgt = free_idx_q;
        end else if (ev_on_q) begin
            use_steal = 1'b1;
        end else begin
            drop = 1'b1;
        end
    end

    // Allocator FSM, slot table and outstanding-update tracking
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            ready_q       <= 1'b1;
            flag_q        <= 1'b0;
            status_q      <= 1'b0;
            index_q       <= '0;
            vnote_q       <= '0;
            ev_on_q       <= 1'b0;
            ev_note_q     <= '0;
            scan_q        <= '0;
            match_q       <= 1'b0;
            free_q        <= 1'b0;
            match_idx_q   <= '0;
            free_idx_q    <= '0;
            steal_q       <= '0;
            outstanding_q <= 1'b0;
            armed_q       <= 1'b0;
            for (int v = 0; v < int'(NUM_VOICES); v++) begin
                busy_q[v] <= 1'b0;
                note_q[v] <= '0;
            end
        end else begin
            flag_q <= 1'b0;
            // A sweep starting in the flag cycle itself does not count as "after" it
            if (outstanding_q) begin
                if (sweep_start_i && !flag_q) armed_q <= 1'b1;
                if (armed_q && slot_update_i) begin
                    outstanding_q <= 1'b0;
                    armed_q       <= 1'b0;
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (note_valid_i) begin
                        ev_on_q   <= note_on_i;
                        ev_note_q <= note_num_i;
                        scan_q    <= '0;
                        match_q   <= 1'b0;
                        free_q    <= 1'b0;
                        ready_q   <= 1'b0;
                        state_q   <= StSearch;
                    end
                end
                StSearch: begin
                    if (busy_q[scan_q] && note_q[scan_q] == ev_note_q && !match_q) begin
                        match_q     <= 1'b1;
                        match_idx_q <= scan_q;
                    end
                    if (!busy_q[scan_q] && !free_q) begin
                        free_q     <= 1'b1;
                        free_idx_q <= scan_q;
                    end
                    if (scan_q == LastIdx) state_q <= StDecide;
                    else                   scan_q  <= scan_q + 1'b1;
                end
                StDecide: begin
                    if (drop) begin
                        ready_q <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        busy_q[tgt] <= ev_on_q;
                        if (ev_on_q) note_q[tgt] <= ev_note_q;
                        if (use_steal) steal_q <= (steal_q == LastIdx) ? '0 : steal_q + 1'b1;
                        status_q <= ev_on_q;
                        index_q  <= 8'(tgt);
                        vnote_q  <= ev_note_q;
                        state_q  <= StIssue;
                    end
                end
                StIssue: begin
                    if (!outstanding_q) begin
                        flag_q        <= 1'b1;
                        outstanding_q <= 1'b1;
                        armed_q       <= 1'b0;
                        ready_q       <= 1'b1;
                        state_q       <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign note_ready_o      = ready_q;
    assign spi_flag_o        = flag_q;
    assign spi_note_status_o = status_q;
    assign spi_voice_index_o = index_q;
    assign voice_note_o      = vnote_q;

endmodule

// File: rtl/voice_scheduler.sv
// Frame sequencer: sweeps every voice through the 4-phase pipeline once per sample
// frame, accumulates the enveloped voice samples into a saturated mix, and hosts the
// note-event voice allocator.
module voice_scheduler
    import synth_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned SAMPLE_DIV = 1024,
    parameter int unsigned ACC_W      = 24
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_note_valid,
    input  logic               i_note_on,
    input  logic [NOTE_W-1:0]  i_note_num,
    output logic               o_note_ready,
    output logic               o_spi_flag,
    output logic               o_spi_note_status,
    output logic [7:0]         o_spi_voice_index,
    output logic [NOTE_W-1:0]  o_voice_note,
    output logic [7:0]         o_voice_index,
    output logic [1:0]         o_pipeline_state,
    input  logic signed [15:0] i_voice_sample,
    output logic signed [15:0] o_mix_sample,
    output logic               o_mix_valid
);

    localparam int unsigned            CntW      = $clog2(SAMPLE_DIV);
    localparam logic [CntW-1:0]        CntLast   = CntW'(SAMPLE_DIV - 1);
    localparam logic [CntW-1:0]        SweepLast = CntW'(4 * NUM_VOICES - 1);
    localparam logic [7:0]             VoiceLast = 8'(NUM_VOICES - 1);
    localparam logic signed [ACC_W-1:0] SatMax   = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SatMin   = ACC_W'(-32768);

    logic [CntW-1:0]         cnt_q;
    logic [1:0]              phase_q;
    logic [7:0]              voice_q;
    logic                    sweep_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [15:0]      mix_q;
    logic                    mix_valid_q;

    logic signed [ACC_W-1:0] sample_ext, acc_sum;
    logic signed [15:0]      mix_sat;
    logic                    capture, last_capture, sweep_start, slot_update;

    // Capture arithmetic and saturation of the running sum
    always_comb begin
        sample_ext   = ACC_W'(i_voice_sample);
        acc_sum      = acc_q + sample_ext;
        capture      = sweep_q && (phase_q == PH_IDLE);
        last_capture = capture && (voice_q == VoiceLast);
        sweep_start  = sweep_q && (phase_q == PH_READ) && (voice_q == '0);
        slot_update  = sweep_q && (phase_q == PH_UPDATE);
        if (acc_sum > SatMax)      mix_sat = 16'sh7fff;
        else if (acc_sum < SatMin) mix_sat = -16'sh8000;
        else                       mix_sat = acc_sum[15:0];
    end

    // Frame counter and registered pipeline phase / voice index
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q   <= '0;
            phase_q <= PH_IDLE;
            voice_q <= '0;
            sweep_q <= 1'b0;
        end else begin
            cnt_q <= (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
            if (cnt_q <= SweepLast) begin
                phase_q <= cnt_q[1:0];
                voice_q <= 8'(cnt_q >> 2);
                sweep_q <= 1'b1;
            end else begin
                phase_q <= PH_IDLE;
                sweep_q <= 1'b0;
            end
        end
    end

    // Mix accumulator: cleared as a sweep is launched, one add per voice in phase 3
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            acc_q       <= '0;
            mix_q       <= '0;
            mix_valid_q <= 1'b0;
        end else begin
            mix_valid_q <= 1'b0;
            if (capture) acc_q <= acc_sum;
            if (cnt_q == '0) acc_q <= '0;
            if (last_capture) begin
                mix_q       <= mix_sat;
                mix_valid_q <= 1'b1;
            end
        end
    end

    voice_allocator #(
        .NUM_VOICES (NUM_VOICES)
    ) u_alloc (
        .clk_i             (i_clk),
        .rst_ni            (i_reset_n),
        .note_valid_i      (i_note_valid),
        .note_on_i         (i_note_on),
        .note_num_i        (i_note_num),
        .note_ready_o      (o_note_ready),
        .sweep_start_i     (sweep_start),
        .slot_update_i     (slot_update),
        .spi_flag_o        (o_spi_flag),
        .spi_note_status_o (o_spi_note_status),
        .spi_voice_index_o (o_spi_voice_index),
        .voice_note_o      (o_voice_note)
    );

    assign o_voice_index    = voice_q;
    assign o_pipeline_state = phase_q;
    assign o_mix_sample     = mix_q;
    assign o_mix_valid      = mix_valid_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Self-checking bench for voice_scheduler: sweep timing, saturated mix, voice allocation.
module tb_voice_scheduler;

    localparam int NV = 8;
    localparam int SD = 64;
    localparam int AW = 24;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              note_valid = 1'b0;
    logic              note_on = 1'b0;
    logic [6:0]        note_num = '0;
    logic              note_ready, spi_flag, spi_status, mix_valid;
    logic [7:0]        spi_index, voice_index;
    logic [6:0]        voice_note;
    logic [1:0]        pipe_state;
    logic signed [15:0] mix_sample;
    logic signed [15:0] voice_sample;
    logic signed [15:0] samp [NV];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rel = 0;

    // Reference allocator state
    bit         m_busy [NV];
    logic [6:0] m_note [NV];
    int         m_steal = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign voice_sample = samp[voice_index[2:0]];

    voice_scheduler #(
        .NUM_VOICES (NV),
        .SAMPLE_DIV (SD),
        .ACC_W      (AW)
    ) dut (
        .i_clk             (clk),
        .i_reset_n         (rst_n),
        .i_note_valid      (note_valid),
        .i_note_on         (note_on),
        .i_note_num        (note_num),
        .o_note_ready      (note_ready),
        .o_spi_flag        (spi_flag),
        .o_spi_note_status (spi_status),
        .o_spi_voice_index (spi_index),
        .o_voice_note      (voice_note),
        .o_voice_index     (voice_index),
        .o_pipeline_state  (pipe_state),
        .i_voice_sample    (voice_sample),
        .o_mix_sample      (mix_sample),
        .o_mix_valid       (mix_valid)
    );

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat16(input int s);
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    function automatic int frame_sum();
        int s = 0;
        for (int i = 0; i < NV; i++) s += int'(samp[i]);
        return sat16(s);
    endfunction

    // Two keystate strobes must always be separated by a PH_UPDATE cycle
    bit any_flag = 1'b0;
    bit upd_seen = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            any_flag = 1'b0;
            upd_seen = 1'b0;
        end else begin
            if (spi_flag) begin
                if (any_flag) check("flag_spacing", 32'(upd_seen), 1);
                any_flag = 1'b1;
                upd_seen = 1'b0;
            end
            if (pipe_state == 2'd2) upd_seen = 1'b1;
        end
    end

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_busy[v] = 1'b0;
            m_note[v] = '0;
        end
        m_steal = 0;
    endtask

    task automatic model_event(input bit on, input logic [6:0] n, output bit f,
                               output int idx, output bit st);
        int match = -1;
        int free = -1;
        for (int v = 0; v < NV; v++) begin
            if (m_busy[v] && m_note[v] == n && match < 0) match = v;
            if (!m_busy[v] && free < 0) free = v;
        end
        f = 1'b1; st = on; idx = 0;
        if (on) begin
            if (match >= 0)     idx = match;
            else if (free >= 0) idx = free;
            else begin
                idx = m_steal;
                m_steal = (m_steal + 1) % NV;
            end
            m_busy[idx] = 1'b1;
            m_note[idx] = n;
        end else if (match >= 0) begin
            idx = match;
            m_busy[idx] = 1'b0;
        end else begin
            f = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
    endtask

    task automatic wait_mix(output int at);
        int t = 0;
        @(negedge clk);
        while (!mix_valid && t < 2 * SD) begin
            @(negedge clk);
            t++;
        end
        if (!mix_valid) check("mix_timeout", 0, 1);
        at = cyc;
    endtask

    task automatic send(input bit on, input logic [6:0] n);
        int t = 0;
        while (!note_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!note_ready) check("ready_timeout", 0, 1);
        note_valid = 1'b1;
        note_on    = on;
        note_num   = n;
        @(negedge clk);
        note_valid = 1'b0;
        check("ready_drop", 32'(note_ready), 0);
    endtask

    task automatic expect_evt(input string tag, input bit on, input logic [6:0] n,
                              output int fk);
        bit ef, est, seen;
        int eidx;
        int t = 0;
        model_event(on, n, ef, eidx, est);
        send(on, n);
        seen = 1'b0;
        fk = -1;
        if (ef) begin
            while (!seen && t < 300) begin
                @(negedge clk);
                t++;
                if (spi_flag) begin
                    seen = 1'b1;
                    fk = cyc - rel - 1;
                    check({tag, "_idx"}, 32'(spi_index), eidx);
                    check({tag, "_status"}, 32'(spi_status), 32'(est));
                    check({tag, "_note"}, 32'(voice_note), 32'(n));
                end
            end
            check({tag, "_flag"}, 32'(seen), 1);
        end else begin
            while (!note_ready && t < 300) begin
                @(negedge clk);
                t++;
                if (spi_flag) seen = 1'b1;
            end
            check({tag, "_noflag"}, 32'(seen), 0);
            check({tag, "_ready"}, 32'(note_ready), 1);
        end
    endtask

    initial begin
        int t0, t1, fa, fb, t;
        for (int i = 0; i < NV; i++) samp[i] = '0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(pipe_state), 3);
        check("rst_ready", 32'(note_ready), 1);
        check("rst_flag", 32'(spi_flag), 0);
        check("rst_mixv", 32'(mix_valid), 0);
        check("rst_mix", mix_sample, 0);
        check("rst_vidx", 32'(voice_index), 0);
        check("rst_sidx", 32'(spi_index), 0);
        @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;

        // Sweep shape over the first frame
        t0 = 0;
        for (int k = 0; k < SD; k++) begin
            @(negedge clk);
            check("sweep_state", 32'(pipe_state), (k < 4 * NV) ? k % 4 : 3);
            check("sweep_voice", 32'(voice_index), (k < 4 * NV) ? k / 4 : NV - 1);
            check("sweep_mixv", 32'(mix_valid), (k == 4 * NV) ? 1 : 0);
            if (k == 4 * NV) begin
                t0 = cyc;
                check("mix_zero", mix_sample, 0);
            end
        end

        // Mix values: directed then random
        for (int i = 0; i < NV; i++) samp[i] = 16'sd1000;
        wait_mix(t1);
        check("mix_period", t1 - t0, SD);
        check("mix_1000", mix_sample, 8000);
        for (int i = 0; i < NV; i++) samp[i] = 16'sd32767;
        wait_mix(t1);
        check("mix_satpos", mix_sample, 32767);
        for (int i = 0; i < NV; i++) samp[i] = -16'sd32768;
        wait_mix(t1);
        check("mix_satneg", mix_sample, -32768);
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < NV; i++) begin
                int r = (f < 2) ? int'($urandom_range(0, 16000)) - 8000
                                : int'($urandom_range(0, 65535)) - 32768;
                samp[i] = 16'(r);
            end
            wait_mix(t1);
            check("mix_rand", mix_sample, frame_sum());
        end

        // Allocation basics
        do_reset();
        expect_evt("on60", 1'b1, 7'd60, fa);
        expect_evt("on62", 1'b1, 7'd62, fa);
        expect_evt("on64", 1'b1, 7'd64, fa);
        expect_evt("off62", 1'b0, 7'd62, fa);
        expect_evt("on65", 1'b1, 7'd65, fa);

        // Stealing when all slots are busy
        do_reset();
        for (int n = 60; n <= 68; n++) expect_evt("fill", 1'b1, 7'(n), fa);
        expect_evt("steal2", 1'b1, 7'd70, fa);

        // Dropped note-off, retrigger of the same note
        expect_evt("off99", 1'b0, 7'd99, fa);
        expect_evt("re60a", 1'b1, 7'd60, fa);
        expect_evt("re60b", 1'b1, 7'd60, fb);

        // Back-to-back events after reset: second strobe waits for the next frame
        do_reset();
        expect_evt("b2b_a", 1'b1, 7'd50, fa);
        expect_evt("b2b_b", 1'b1, 7'd51, fb);
        check("b2b_held", 32'(fb >= SD + 3), 1);

        // Reset in the middle of a sweep
        t = 0;
        while (!(pipe_state == 2'd1 && voice_index == 8'd3) && t < 2 * SD) begin
            @(negedge clk);
            t++;
        end
        check("mid_found", 32'(pipe_state == 2'd1 && voice_index == 8'd3), 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_state", 32'(pipe_state), 3);
        check("mid_flag", 32'(spi_flag), 0);
        check("mid_mixv", 32'(mix_valid), 0);
        check("mid_ready", 32'(note_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        for (int k = 0; k <= 4 * NV; k++) begin
            @(negedge clk);
            check("mid_mixv_k", 32'(mix_valid), (k == 4 * NV) ? 1 : 0);
            if (k == 4 * NV) check("mid_mix", mix_sample, frame_sum());
        end

        // Random note traffic against the reference allocator
        for (int e = 0; e < 24; e++) begin
            bit on = ($urandom_range(0, 2) != 0);
            expect_evt("rand_evt", on, 7'($urandom_range(60, 71)), fa);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
